// File: rtl/roi_cropper.sv
// Region-of-interest cropper with per-axis decimation for a DE/VS pixel stream.
// Config is shadowed at each frame start; output is a fixed one-clock delay of the input.
module roi_cropper #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned X_WIDTH    = 12,
    parameter int unsigned Y_WIDTH    = 12,
    parameter int unsigned H_DISP     = 1280,
    parameter int unsigned V_DISP     = 720
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [X_WIDTH-1:0]    start_x,
    input  logic [X_WIDTH-1:0]    end_x,
    input  logic [Y_WIDTH-1:0]    start_y,
    input  logic [Y_WIDTH-1:0]    end_y,
    input  logic [1:0]            step_x,
    input  logic [1:0]            step_y,
    input  logic                  pre_vs,
    input  logic                  pre_de,
    input  logic [DATA_WIDTH-1:0] pre_data,
    output logic                  post_vs,
    output logic                  post_de,
    output logic [DATA_WIDTH-1:0] post_data,
    output logic                  cfg_err,
    output logic                  frame_done
);

    // Edge detect history
    logic vs_q, de_q;

    logic [X_WIDTH-1:0] h_cnt_q, h_cnt_d;
    logic [Y_WIDTH-1:0] v_cnt_q, v_cnt_d;
    logic [1:0]         h_ph_q, h_ph_d, h_ph_cur;
    logic [1:0]         v_ph_q, v_ph_d, v_ph_cur;

    // Shadow configuration
    logic [X_WIDTH-1:0] sx_q, ex_q, sx_d, ex_d;
    logic [Y_WIDTH-1:0] sy_q, ey_q, sy_d, ey_d;
    logic [1:0]         stx_q, sty_q, stx_d, sty_d;
    logic               cfg_err_q, cfg_err_d;

    logic                  post_vs_q, post_de_q, post_de_d, frame_done_q, frame_done_d;
    logic [DATA_WIDTH-1:0] post_data_q, post_data_d;

    logic vs_rise, de_fall, cfg_bad, in_x, in_y, keep;

    always_comb begin
        vs_rise = pre_vs & ~vs_q;
        de_fall = de_q & ~pre_de;

        cfg_bad = (end_x <= start_x) || (end_y <= start_y) ||
                  (32'(end_x) > H_DISP) || (32'(end_y) > V_DISP);

        // The phase is forced to zero on the first column/line of the region.
        h_ph_cur = (h_cnt_q == sx_q) ? 2'd0 : h_ph_q;
        v_ph_cur = (v_cnt_q == sy_q) ? 2'd0 : v_ph_q;

        in_x = (h_cnt_q >= sx_q) && (h_cnt_q < ex_q);
        in_y = (v_cnt_q >= sy_q) && (v_cnt_q < ey_q);
        keep = en && pre_de && in_x && in_y && (h_ph_cur == 2'd0) && (v_ph_cur == 2'd0);
    end

    always_comb begin
        h_cnt_d = h_cnt_q;
        if (vs_rise || de_fall) begin
            h_cnt_d = '0;
        end else if (pre_de && (h_cnt_q != '1)) begin
            h_cnt_d = h_cnt_q + 1'b1;
        end

        v_cnt_d = v_cnt_q;
        if (vs_rise) begin
            v_cnt_d = '0;
        end else if (de_fall && (v_cnt_q != '1)) begin
            v_cnt_d = v_cnt_q + 1'b1;
        end

        h_ph_d = h_ph_q;
        if (vs_rise) begin
            h_ph_d = 2'd0;
        end else if (pre_de) begin
            h_ph_d = (h_ph_cur == stx_q) ? 2'd0 : h_ph_cur + 2'd1;
        end

        v_ph_d = v_ph_q;
        if (vs_rise) begin
            v_ph_d = 2'd0;
        end else if (de_fall) begin
            v_ph_d = (v_ph_cur == sty_q) ? 2'd0 : v_ph_cur + 2'd1;
        end
    end

    always_comb begin
        sx_d      = sx_q;
        ex_d      = ex_q;
        sy_d      = sy_q;
        ey_d      = ey_q;
        stx_d     = stx_q;
        sty_d     = sty_q;
        cfg_err_d = cfg_err_q;
        if (vs_rise) begin
            if (cfg_bad) begin
                cfg_err_d = 1'b1;
            end else begin
                sx_d      = start_x;
                ex_d      = end_x;
                sy_d      = start_y;
                ey_d      = end_y;
                stx_d     = step_x;
                sty_d     = step_y;
                cfg_err_d = 1'b0;
            end
        end
    end

    always_comb begin
        post_de_d    = en ? keep : pre_de;
        post_data_d  = (!en || keep) ? pre_data : '0;
        frame_done_d = en && de_fall && (v_cnt_q == ey_q - 1'b1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q         <= 1'b0;
            de_q         <= 1'b0;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            h_ph_q       <= 2'd0;
            v_ph_q       <= 2'd0;
            sx_q         <= '0;
            ex_q         <= X_WIDTH'(H_DISP);
            sy_q         <= '0;
            ey_q         <= Y_WIDTH'(V_DISP);
            stx_q        <= 2'd0;
            sty_q        <= 2'd0;
            cfg_err_q    <= 1'b0;
            post_vs_q    <= 1'b0;
            post_de_q    <= 1'b0;
            post_data_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            vs_q         <= pre_vs;
            de_q         <= pre_de;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            h_ph_q       <= h_ph_d;
            v_ph_q       <= v_ph_d;
            sx_q         <= sx_d;
            ex_q         <= ex_d;
            sy_q         <= sy_d;
            ey_q         <= ey_d;
            stx_q        <= stx_d;
            sty_q        <= sty_d;
            cfg_err_q    <= cfg_err_d;
            post_vs_q    <= pre_vs;
            post_de_q    <= post_de_d;
            post_data_q  <= post_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign post_vs    = post_vs_q;
    assign post_de    = post_de_q;
    assign post_data  = post_data_q;
    assign cfg_err    = cfg_err_q;
    assign frame_done = frame_done_q;

endmodule
